// File: rtl/mem_access_ctrl_if.sv
// Memory-side request/acknowledge bus between the M-stage controller and data memory.
// The controller drives the request fields; memory answers with a one-cycle ack and load data.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage memory access controller: issues one req/ack transaction per load/store,
// stalls the pipeline until completion, and flags misaligned and timed-out accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  mem_access_ctrl_if.master memBus,
  output logic              StallM,
  output logic [31:0]       ReadDataM,
  output logic              misalignM,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  acc_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            stateReg;
  logic              reqReg;
  logic              weReg;
  logic [31:0]       addrReg;
  logic [31:0]       wdataReg;
  logic [CNT_W-1:0]  waitCntReg;

  logic acc;
  logic aligned;

  assign acc     = MemtoRegM | MemWriteM;
  assign aligned = (ALUOutM[1:0] == 2'b00);

  // Purely state + M-stage inputs; mem_ack must never reach StallM.
  assign StallM = (stateReg == BUSY) || ((stateReg == IDLE) && acc && aligned);

  assign memBus.mem_req   = reqReg;
  assign memBus.mem_we    = weReg;
  assign memBus.mem_addr  = addrReg;
  assign memBus.mem_wdata = wdataReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      reqReg      <= 1'b0;
      weReg       <= 1'b0;
      addrReg     <= '0;
      wdataReg    <= '0;
      waitCntReg  <= '0;
      ReadDataM   <= '0;
      misalignM   <= 1'b0;
      timeout_err <= 1'b0;
      acc_count   <= '0;
    end else begin
      misalignM <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (acc) begin
            if (aligned) begin
              reqReg     <= 1'b1;
              weReg      <= MemWriteM;
              addrReg    <= ALUOutM;
              wdataReg   <= WriteDataM;
              waitCntReg <= '0;
              stateReg   <= BUSY;
            end else begin
              misalignM <= 1'b1;
            end
          end
        end

        BUSY: begin
          waitCntReg <= waitCntReg + CNT_W'(1);
          // An ack in the last allowed cycle still counts as a normal completion.
          if (memBus.mem_ack) begin
            reqReg    <= 1'b0;
            if (!weReg) ReadDataM <= memBus.mem_rdata;
            acc_count <= acc_count + CNT_W'(1);
            stateReg  <= DONE;
          end else if (waitCntReg == LAST_WAIT) begin
            reqReg      <= 1'b0;
            if (!weReg) ReadDataM <= '0;
            timeout_err <= 1'b1;
            acc_count   <= acc_count + CNT_W'(1);
            stateReg    <= DONE;
          end
        end

        // The instruction that just completed is still in M; let it leave without re-issuing.
        DONE: stateReg <= IDLE;

        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule
